// File: rtl/decimal_key_scanner.sv
// decimal_key_scanner: synchronizes and debounces ten decimal key lines and
// emits one BCD digit per press over a valid/ready handshake. It then waits
// for a debounced full release before it accepts another press.
// Optional feature macro: KEY_MULTI_ERR_EN. When it is defined, a multi-key
// press in IDLE or DEBOUNCE is rejected and reported on the err port.
module decimal_key_scanner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_in,
    output logic [3:0] bcd_out,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic       busy
`ifdef KEY_MULTI_ERR_EN
    ,
    output logic       err
`endif
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StEmit,
        StWaitRelease
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [9:0]    r_key_meta;
    logic [9:0]    r_key_s;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic [3:0]    r_sel;
    logic [3:0]    w_sel_next;
    logic [3:0]    w_low_idx;
    logic          w_sel_hit;
    logic          w_multi;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_sel_hit = |(r_key_s & (10'd1 << r_sel));

`ifdef KEY_MULTI_ERR_EN
    // More than one key line set: clearing the lowest set bit leaves something.
    assign w_multi = |(r_key_s & (r_key_s - 10'd1));
`else
    assign w_multi = 1'b0;
`endif

    // Priority encoder: index of the lowest set synchronized key.
    always_comb begin
        w_low_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (r_key_s[i]) w_low_idx = 4'(i);
        end
    end

    // Two-flop synchronizer on the raw key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta <= '0;
            r_key_s    <= '0;
        end else begin
            r_key_meta <= key_in;
            r_key_s    <= r_key_meta;
        end
    end

    // State, debounce counter and selected-key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_sel   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sel   <= w_sel_next;
        end
    end

    // Next-state logic; the counter is cleared on every state change.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sel_next   = r_sel;
        unique case (r_state)
            StIdle: begin
                if (w_multi) begin
                    w_state_next = StWaitRelease;
                    w_cnt_next   = '0;
                end else if (r_key_s != 10'd0) begin
                    w_sel_next   = w_low_idx;
                    w_cnt_next   = '0;
                    w_state_next = StDebounce;
                end
            end
            StDebounce: begin
                if (w_multi) begin
                    w_state_next = StWaitRelease;
                    w_cnt_next   = '0;
                end else if (!w_sel_hit) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc == DC) begin
                    w_state_next = StEmit;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            StEmit: begin
                // Releasing the key here does not cancel the pending digit.
                if (bcd_ready) begin
                    w_state_next = StWaitRelease;
                    w_cnt_next   = '0;
                end
            end
            StWaitRelease: begin
                if (r_key_s != 10'd0) begin
                    w_cnt_next = '0;
                end else if (w_cnt_inc == DC) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
        endcase
    end

`ifdef KEY_MULTI_ERR_EN
    // One-cycle error pulse in the cycle after a multi-key rejection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= w_multi && ((r_state == StIdle) || (r_state == StDebounce));
        end
    end
`endif

    // Outputs decoded from state; the digit reads as 0 while no digit is valid.
    always_comb begin
        bcd_valid = (r_state == StEmit);
        bcd_out   = bcd_valid ? r_sel : 4'd0;
        busy      = (r_state != StIdle);
    end

endmodule

// File: tb/tb_decimal_key_scanner.sv
// Directed testbench for decimal_key_scanner with DEBOUNCE_CYCLES = 4.
module tb_decimal_key_scanner;

    logic       clk;
    logic       rst_n;
    logic [9:0] key_in;
    logic [3:0] bcd_out;
    logic       bcd_valid;
    logic       bcd_ready;
    logic       busy;
`ifdef KEY_MULTI_ERR_EN
    logic       err;
`endif

    int n_cmp;
    int n_bad;

    decimal_key_scanner #(
        .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .bcd_out  (bcd_out),
        .bcd_valid(bcd_valid),
        .bcd_ready(bcd_ready),
        .busy     (busy)
`ifdef KEY_MULTI_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop all keys and wait (bounded) for the FSM to return to IDLE.
    task automatic release_to_idle(input string tag);
        logic seen;
        seen   = 1'b0;
        key_in = 10'd0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (!busy) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int   vcnt;
        int   hs;
        logic stable;
        logic got;
        logic [3:0] dig;

        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        key_in    = 10'd0;
        bcd_ready = 1'b0;
        #12;
        check_eq("rst_valid", 32'(bcd_valid), 32'd0);
        check_eq("rst_bcd", 32'(bcd_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();

        // Key 5 with ready high: valid exactly at edge 6 for one cycle.
        bcd_ready = 1'b1;
        key_in    = 10'b0000100000;
        for (int e = 0; e <= 6; e++) begin
            step();
            if (e == 1) check_eq("k5_busy_e1", 32'(busy), 32'd0);
            if (e == 2) check_eq("k5_busy_e2", 32'(busy), 32'd1);
            if (e == 5) check_eq("k5_valid_e5", 32'(bcd_valid), 32'd0);
        end
        check_eq("k5_valid_e6", 32'(bcd_valid), 32'd1);
        check_eq("k5_bcd_e6", 32'(bcd_out), 32'd5);
        step();
        check_eq("k5_valid_e7", 32'(bcd_valid), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bcd_valid) vcnt++;
        end
        check_eq("k5_no_repeat", 32'(vcnt), 32'd0);
        // Release before edge r: busy through edge r+4, IDLE at edge r+5.
        key_in = 10'd0;
        for (int i = 0; i < 5; i++) step();
        check_eq("k5_busy_r4", 32'(busy), 32'd1);
        step();
        check_eq("k5_idle_r5", 32'(busy), 32'd0);

        // Key 9 with ready low: digit held stable, handshake on first ready.
        bcd_ready = 1'b0;
        key_in    = 10'b1000000000;
        for (int e = 0; e <= 6; e++) step();
        check_eq("k9_valid", 32'(bcd_valid), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bcd_valid || bcd_out != 4'd9) stable = 1'b0;
        end
        check_eq("k9_stable", 32'(stable), 32'd1);
        bcd_ready = 1'b1;
        step();
        check_eq("k9_hs_valid", 32'(bcd_valid), 32'd0);
        check_eq("k9_hs_busy", 32'(busy), 32'd1);
        release_to_idle("k9_idle");

        // Two-cycle glitch on key 3: aborted, nothing emitted.
        key_in = 10'b0000001000;
        step();
        step();
        key_in = 10'd0;
        vcnt   = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bcd_valid) vcnt++;
        end
        check_eq("glitch_no_valid", 32'(vcnt), 32'd0);
        check_eq("glitch_idle", 32'(busy), 32'd0);

        // Keys 1 and 4 together.
        key_in = 10'b0000010010;
`ifdef KEY_MULTI_ERR_EN
        vcnt = 0;
        hs   = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (err) vcnt++;
            if (bcd_valid) hs++;
        end
        check_eq("multi_err_pulses", 32'(vcnt), 32'd1);
        check_eq("multi_no_valid", 32'(hs), 32'd0);
`else
        for (int e = 0; e <= 6; e++) step();
        check_eq("multi_valid", 32'(bcd_valid), 32'd1);
        check_eq("multi_low_wins", 32'(bcd_out), 32'd1);
`endif
        release_to_idle("multi_idle");

        // Asynchronous reset while a digit is pending.
        bcd_ready = 1'b0;
        key_in    = 10'b0010000000;
        for (int e = 0; e <= 6; e++) step();
        check_eq("rstmid_valid_pre", 32'(bcd_valid), 32'd1);
        #2;
        rst_n  = 1'b0;
        key_in = 10'd0;
        #1;
        check_eq("rstmid_valid", 32'(bcd_valid), 32'd0);
        check_eq("rstmid_bcd", 32'(bcd_out), 32'd0);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        vcnt  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bcd_valid || busy) vcnt++;
        end
        check_eq("rstmid_quiet", 32'(vcnt), 32'd0);

        // Sweep digits 0-9 with full release in between.
        bcd_ready = 1'b1;
        hs        = 0;
        for (int d = 0; d < 10; d++) begin
            key_in = 10'd1 << d;
            got    = 1'b0;
            dig    = 4'hf;
            for (int i = 0; i < 30; i++) begin
                step();
                if (bcd_valid) begin
                    hs++;
                    if (!got) dig = bcd_out;
                    got = 1'b1;
                end
            end
            check_eq($sformatf("sweep_digit_%0d", d), 32'(dig), 32'(d));
            release_to_idle($sformatf("sweep_idle_%0d", d));
        end
        check_eq("sweep_handshakes", 32'(hs), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
